// File: rtl/srio_nwr_gen.sv
// SRIO NWRITE stream generator.
// Emits one fixed-size NWRITE packet per start request, with a one-deep
// pending start and a saturating count of dropped starts.
// Optional build macro: SRIO_NWR_GEN_PRBS_EN selects a PRBS-31 payload
// (x^31 + x^28 + 1); the counter payload is used when it is undefined.
module srio_nwr_gen #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 34
) (
    input  logic                 log_clk,
    input  logic                 log_rst_n,
    input  logic                 nwr_ready_in,
    input  logic [8:0]           cfg_tsize_in,
    input  logic [ADDR_W-1:0]    cfg_base_addr_in,
    input  logic                 user_tready_in,
    output logic [ADDR_W-1:0]    user_addr_o,
    output logic [19:0]          user_tsize_o,
    output logic [DATA_W-1:0]    user_tdata_o,
    output logic [DATA_W/8-1:0]  user_tkeep_o,
    output logic                 user_tfirst_o,
    output logic                 user_tvalid_o,
    output logic                 user_tlast_o,
    output logic                 nwr_busy_o,
    output logic                 nwr_done_o,
    output logic [15:0]          drop_cnt_o
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned KB     = $clog2(KEEP_W);
    localparam int unsigned LANES  = DATA_W / 32;

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [15:0]       pkt_seq_q, pkt_seq_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_init_q, addr_init_d;
    logic [8:0]        bytes_q, bytes_d;
    logic [15:0]       beat_q, beat_d;

    logic              accept;
    logic [8:0]        bytes_m1;
    logic [15:0]       last_beat;
    logic              is_last;
    logic [KB-1:0]     rem;
    logic [DATA_W-1:0] tdata_pat;

    assign accept    = (state_q == StSend) && user_tready_in;
    assign bytes_m1  = bytes_q - 9'd1;
    assign last_beat = 16'(bytes_m1 >> KB);
    assign is_last   = (beat_q == last_beat);
    assign rem       = bytes_q[KB-1:0];

`ifdef SRIO_NWR_GEN_PRBS_EN
    logic [30:0]       prbs_q, prbs_d;
    logic [DATA_W-1:0] prbs_bits;

    // Unroll DATA_W LFSR steps; bit i of the beat is the i-th generated bit.
    always_comb begin
        logic [30:0] s;
        s         = prbs_q;
        prbs_bits = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            prbs_bits[i] = s[30] ^ s[27];
            s            = {s[29:0], s[30] ^ s[27]};
        end
        prbs_d = accept ? s : prbs_q;
    end

    // PRBS state register, advances only on accepted beats.
    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) prbs_q <= 31'h7FFF_FFFF;
        else            prbs_q <= prbs_d;
    end

    assign tdata_pat = prbs_bits;
`else
    assign tdata_pat = {LANES{pkt_seq_q, beat_q}};
`endif

    // Next-state logic for the packet FSM and its bookkeeping registers.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        drop_cnt_d  = drop_cnt_q;
        pkt_seq_d   = pkt_seq_q;
        addr_d      = addr_q;
        addr_init_d = 1'b1;
        bytes_d     = bytes_q;
        beat_d      = beat_q;

        // First clock out of reset picks up the configured base address.
        if (!addr_init_q) addr_d = cfg_base_addr_in;

        unique case (state_q)
            StIdle: begin
                if (pending_q || nwr_ready_in) begin
                    state_d   = StLoad;
                    // A fresh start arriving while a pending one is consumed takes its place.
                    pending_d = pending_q && nwr_ready_in;
                end
            end
            StLoad: begin
                bytes_d = (cfg_tsize_in == 9'd0 || cfg_tsize_in > 9'd256) ? 9'd256 : cfg_tsize_in;
                beat_d  = 16'd0;
                state_d = StSend;
            end
            StSend: begin
                if (accept) begin
                    if (is_last) state_d = StDone;
                    else         beat_d  = beat_q + 16'd1;
                end
            end
            StDone: begin
                state_d   = StIdle;
                addr_d    = addr_q + ADDR_W'(bytes_q);
                pkt_seq_d = pkt_seq_q + 16'd1;
            end
            default: state_d = StIdle;
        endcase

        // Starts while busy (including the DONE cycle) queue once, then count as drops.
        if (state_q != StIdle && nwr_ready_in) begin
            if (!pending_q)                    pending_d  = 1'b1;
            else if (drop_cnt_q != 16'hFFFF)   drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            state_q     <= StIdle;
            pending_q   <= 1'b0;
            drop_cnt_q  <= 16'd0;
            pkt_seq_q   <= 16'd0;
            addr_q      <= '0;
            addr_init_q <= 1'b0;
            bytes_q     <= 9'd0;
            beat_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            drop_cnt_q  <= drop_cnt_d;
            pkt_seq_q   <= pkt_seq_d;
            addr_q      <= addr_d;
            addr_init_q <= addr_init_d;
            bytes_q     <= bytes_d;
            beat_q      <= beat_d;
        end
    end

    // Stream and status outputs decoded from registered state only.
    always_comb begin
        user_addr_o   = '0;
        user_tsize_o  = 20'd0;
        user_tdata_o  = '0;
        user_tkeep_o  = '0;
        user_tfirst_o = 1'b0;
        user_tvalid_o = 1'b0;
        user_tlast_o  = 1'b0;
        if (state_q == StSend) begin
            user_addr_o   = addr_q;
            user_tsize_o  = 20'(bytes_m1);
            user_tdata_o  = tdata_pat;
            user_tfirst_o = (beat_q == 16'd0);
            user_tvalid_o = 1'b1;
            user_tlast_o  = is_last;
            if (is_last && rem != '0) user_tkeep_o = (KEEP_W'(1) << rem) - KEEP_W'(1);
            else                      user_tkeep_o = '1;
        end
        nwr_busy_o = (state_q != StIdle);
        nwr_done_o = (state_q == StDone);
        drop_cnt_o = drop_cnt_q;
    end

endmodule

// File: tb/tb_srio_nwr_gen.sv
// Self-checking bench for srio_nwr_gen: 64-bit instance checked through a
// beat scoreboard, plus a 128-bit instance for the wide-bus clamp case.
module tb_srio_nwr_gen;

    localparam int ADDR_W = 34;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 64-bit instance
    logic              start = 1'b0, tready = 1'b1;
    logic [8:0]        tsize = 9'd256;
    logic [ADDR_W-1:0] base = 34'h1000;
    logic [ADDR_W-1:0] addr_o;
    logic [19:0]       tsize_o;
    logic [63:0]       tdata_o;
    logic [7:0]        tkeep_o;
    logic              tfirst_o, tvalid_o, tlast_o, busy_o, done_o;
    logic [15:0]       drop_o;

    // 128-bit instance
    logic              w_start = 1'b0, w_tready = 1'b1;
    logic [8:0]        w_tsize = 9'd0;
    logic [ADDR_W-1:0] w_base = 34'h40;
    logic [ADDR_W-1:0] w_addr_o;
    logic [19:0]       w_tsize_o;
    logic [127:0]      w_tdata_o;
    logic [15:0]       w_tkeep_o;
    logic              w_tfirst_o, w_tvalid_o, w_tlast_o, w_busy_o, w_done_o;
    logic [15:0]       w_drop_o;

    srio_nwr_gen #(.DATA_W(64), .ADDR_W(ADDR_W)) dut (
        .log_clk(clk), .log_rst_n(rst_n), .nwr_ready_in(start), .cfg_tsize_in(tsize),
        .cfg_base_addr_in(base), .user_tready_in(tready), .user_addr_o(addr_o),
        .user_tsize_o(tsize_o), .user_tdata_o(tdata_o), .user_tkeep_o(tkeep_o),
        .user_tfirst_o(tfirst_o), .user_tvalid_o(tvalid_o), .user_tlast_o(tlast_o),
        .nwr_busy_o(busy_o), .nwr_done_o(done_o), .drop_cnt_o(drop_o)
    );

    srio_nwr_gen #(.DATA_W(128), .ADDR_W(ADDR_W)) dut_w (
        .log_clk(clk), .log_rst_n(rst_n), .nwr_ready_in(w_start), .cfg_tsize_in(w_tsize),
        .cfg_base_addr_in(w_base), .user_tready_in(w_tready), .user_addr_o(w_addr_o),
        .user_tsize_o(w_tsize_o), .user_tdata_o(w_tdata_o), .user_tkeep_o(w_tkeep_o),
        .user_tfirst_o(w_tfirst_o), .user_tvalid_o(w_tvalid_o), .user_tlast_o(w_tlast_o),
        .nwr_busy_o(w_busy_o), .nwr_done_o(w_done_o), .drop_cnt_o(w_drop_o)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [19:0]       tsize;
        logic [127:0]      data;
        logic [15:0]       keep;
        logic              first;
        logic              last;
    } beat_t;

    beat_t q[$];
    beat_t qw[$];
    int n_cmp = 0;
    int n_err = 0;

    logic [ADDR_W-1:0] m_addr, mw_addr;
    logic [15:0]       m_seq, mw_seq;

    // Reference model: expand one start into its expected beats.
    task automatic push_pkt(input int unsigned ts, input bit wide);
        int unsigned kw, bytes, beats, rem;
        beat_t e;
        logic [15:0] seq;
        logic [ADDR_W-1:0] a;
        kw    = wide ? 16 : 8;
        bytes = (ts == 0 || ts > 256) ? 256 : ts;
        beats = (bytes + kw - 1) / kw;
        rem   = bytes % kw;
        seq   = wide ? mw_seq : m_seq;
        a     = wide ? mw_addr : m_addr;
        for (int b = 0; b < int'(beats); b++) begin
            e.addr  = a;
            e.tsize = 20'(bytes - 1);
            e.data  = '0;
            for (int l = 0; l < int'(kw / 4); l++) e.data[l*32 +: 32] = {seq, 16'(b)};
            e.first = (b == 0);
            e.last  = (b == int'(beats) - 1);
            if (e.last && rem != 0) e.keep = 16'((1 << rem) - 1);
            else                    e.keep = wide ? 16'hFFFF : 16'h00FF;
            if (wide) qw.push_back(e);
            else      q.push_back(e);
        end
        if (wide) begin mw_addr = a + ADDR_W'(bytes); mw_seq = seq + 16'd1; end
        else      begin m_addr  = a + ADDR_W'(bytes); m_seq  = seq + 16'd1; end
    endtask

    // Monitor for the 64-bit instance: scoreboard pop, stall hold, done pulse.
    logic              exp_done = 1'b0;
    logic              prev_stall = 1'b0;
    logic [ADDR_W+94:0] prev_snap;
    beat_t             mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (exp_done) begin
                n_cmp++;
                if (done_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL done_pulse: got %b want 1", done_o);
                end
                exp_done = 1'b0;
            end else if (done_o === 1'b1) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_spurious: got 1 want 0");
            end
            if (prev_stall) begin
                n_cmp++;
                if ({addr_o, tsize_o, tdata_o, tkeep_o, tfirst_o, tvalid_o, tlast_o} !== prev_snap) begin
                    n_err++;
                    $display("FAIL stall_hold: got %h want %h",
                             {addr_o, tsize_o, tdata_o, tkeep_o, tfirst_o, tvalid_o, tlast_o}, prev_snap);
                end
            end
            if (tvalid_o === 1'b1 && tready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_extra: got data %h want no beat", tdata_o);
                end else begin
                    mon_e = q.pop_front();
                    if (addr_o !== mon_e.addr || tsize_o !== mon_e.tsize ||
                        tdata_o !== mon_e.data[63:0] || tkeep_o !== mon_e.keep[7:0] ||
                        tfirst_o !== mon_e.first || tlast_o !== mon_e.last) begin
                        n_err++;
                        $display("FAIL beat: got addr=%h tsize=%h data=%h keep=%h first=%b last=%b want addr=%h tsize=%h data=%h keep=%h first=%b last=%b",
                                 addr_o, tsize_o, tdata_o, tkeep_o, tfirst_o, tlast_o,
                                 mon_e.addr, mon_e.tsize, mon_e.data[63:0], mon_e.keep[7:0],
                                 mon_e.first, mon_e.last);
                    end
                    if (mon_e.last) exp_done = 1'b1;
                end
            end
            prev_stall = (tvalid_o === 1'b1) && !tready;
            prev_snap  = {addr_o, tsize_o, tdata_o, tkeep_o, tfirst_o, tvalid_o, tlast_o};
        end
    end

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((q.size() != 0 || busy_o !== 1'b0) && k < max_cyc);
        @(negedge clk);
        n_cmp++;
        if (q.size() != 0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: got %0d beats left busy=%b want 0 beats busy=0", q.size(), busy_o);
        end
    endtask

    task automatic test_reset();
        m_addr = 34'h1000; m_seq = 16'd0;
        mw_addr = 34'h40;  mw_seq = 16'd0;
        #12;
        n_cmp++;
        if ({tvalid_o, tfirst_o, tlast_o, busy_o, done_o} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 00000", {tvalid_o, tfirst_o, tlast_o, busy_o, done_o});
        end
        n_cmp++;
        if (addr_o !== '0 || tsize_o !== 20'd0 || tdata_o !== 64'd0 || tkeep_o !== 8'd0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h tsize=%h data=%h keep=%h want all 0",
                     addr_o, tsize_o, tdata_o, tkeep_o);
        end
        n_cmp++;
        if (drop_o !== 16'd0 || w_tvalid_o !== 1'b0 || w_busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_misc: got drop=%h wvalid=%b wbusy=%b want 0 0 0",
                     drop_o, w_tvalid_o, w_busy_o);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // 256-byte packets from base 0x1000, plus LOAD-cycle latency check.
    task automatic test_full_packet();
        tsize = 9'd256;
        push_pkt(256, 1'b0);
        start_pulse();
        n_cmp++;
        if (tvalid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL load_cycle: got valid=%b busy=%b want 0 1", tvalid_o, busy_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (tvalid_o !== 1'b1) begin
            n_err++;
            $display("FAIL valid_rise: got %b want 1", tvalid_o);
        end
        wait_idle(100);
        push_pkt(256, 1'b0);
        start_pulse();
        wait_idle(100);
    endtask

    task automatic test_partial();
        int unsigned sizes[4] = '{13, 5, 300, 0};
        foreach (sizes[i]) begin
            tsize = 9'(sizes[i]);
            push_pkt(sizes[i], 1'b0);
            start_pulse();
            wait_idle(100);
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        tsize = 9'd64;
        push_pkt(64, 1'b0);
        start_pulse();
        while ((q.size() != 0 || busy_o) && k < 100) begin
            @(posedge clk); #1 tready = ~tready;
            k++;
        end
        tready = 1'b1;
        wait_idle(50);
    endtask

    // One start begins a packet, three more arrive while it is busy.
    task automatic test_back_to_back();
        tsize = 9'd64;
        push_pkt(64, 1'b0);
        start_pulse();
        push_pkt(64, 1'b0);
        repeat (3) start_pulse();
        n_cmp++;
        if (drop_o !== 16'd2) begin
            n_err++;
            $display("FAIL drop_cnt: got %0d want 2", drop_o);
        end
        wait_idle(200);
        n_cmp++;
        if (drop_o !== 16'd2) begin
            n_err++;
            $display("FAIL drop_hold: got %0d want 2", drop_o);
        end
    endtask

    // A start landing exactly in the DONE cycle is queued, not dropped.
    task automatic test_start_in_done();
        int k = 0;
        tsize = 9'd8;
        push_pkt(8, 1'b0);
        start_pulse();
        do begin
            @(negedge clk);
            k++;
        end while (done_o !== 1'b1 && k < 20);
        start = 1'b1;
        push_pkt(8, 1'b0);
        @(posedge clk); #1 start = 1'b0;
        n_cmp++;
        if (drop_o !== 16'd2 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_done: got drop=%0d busy=%b want 2 0", drop_o, busy_o);
        end
        wait_idle(50);
    endtask

    // 128-bit instance, tsize 0 clamps to 256 bytes = 16 beats.
    task automatic test_wide();
        beat_t e;
        int k = 0;
        int beats = 0;
        w_tsize = 9'd0;
        push_pkt(0, 1'b1);
        @(posedge clk); #1 w_start = 1'b1;
        @(posedge clk); #1 w_start = 1'b0;
        while (qw.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
            if (w_tvalid_o === 1'b1) begin
                e = qw.pop_front();
                beats++;
                n_cmp++;
                if (w_addr_o !== e.addr || w_tsize_o !== e.tsize || w_tdata_o !== e.data ||
                    w_tkeep_o !== e.keep || w_tfirst_o !== e.first || w_tlast_o !== e.last) begin
                    n_err++;
                    $display("FAIL wide_beat: got tsize=%h data=%h keep=%h want tsize=%h data=%h keep=%h",
                             w_tsize_o, w_tdata_o, w_tkeep_o, e.tsize, e.data, e.keep);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (beats != 16 || w_done_o !== 1'b1) begin
            n_err++;
            $display("FAIL wide_count: got beats=%0d done=%b want 16 1", beats, w_done_o);
        end
    endtask

    // Reset at beat 3 of 8, then a new packet from a new base with pkt_seq 0.
    task automatic test_mid_reset();
        int k = 0;
        tsize = 9'd64;
        push_pkt(64, 1'b0);
        start_pulse();
        do begin
            @(negedge clk);
            k++;
        end while (!(tvalid_o === 1'b1 && tdata_o[15:0] == 16'd3) && k < 30);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tvalid_o, tlast_o, tfirst_o, busy_o, done_o} !== 5'b0 || tdata_o !== 64'd0 ||
            addr_o !== '0 || drop_o !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset: got ctl=%b data=%h addr=%h drop=%0d want all 0",
                     {tvalid_o, tlast_o, tfirst_o, busy_o, done_o}, tdata_o, addr_o, drop_o);
        end
        q.delete();
        base   = 34'h2_0000_0040;
        m_addr = 34'h2_0000_0040;
        m_seq  = 16'd0;
        @(negedge clk) rst_n = 1'b1;
        tsize = 9'd24;
        push_pkt(24, 1'b0);
        start_pulse();
        wait_idle(50);
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_start_in_done();
        test_wide();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/srio_nwr_gen.md
SRIO_NWR_GEN -- requirements
Module: srio_nwr_gen

Interface
REQ-001 The block SHALL take parameter DATA_W, default 64, as the stream data width; legal values are 64 and 128.
REQ-002 The block SHALL take parameter ADDR_W, default 34, as the SRIO byte-address width.
REQ-003 The block SHALL derive localparam KEEP_W = DATA_W/8.
REQ-004 The block SHALL have port log_clk, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port log_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port nwr_ready_in, input, 1 bit: single-cycle packet start request.
REQ-007 The block SHALL have port cfg_tsize_in, input, 9 bits: payload byte count.
REQ-008 The block SHALL have port cfg_base_addr_in, input, ADDR_W bits: address of the first packet after reset.
REQ-009 The block SHALL have port user_tready_in, input, 1 bit: downstream ready.
REQ-010 The block SHALL have output ports user_addr_o (ADDR_W bits), user_tsize_o (20 bits), user_tdata_o (DATA_W bits), user_tkeep_o (KEEP_W bits), and user_tfirst_o, user_tvalid_o, user_tlast_o (1 bit each): the NWRITE stream.
REQ-011 The block SHALL have output ports nwr_busy_o and nwr_done_o (1 bit each) and drop_cnt_o (16 bits): status.

Function
REQ-012 The block SHALL implement states IDLE, LOAD, SEND and DONE.
REQ-013 IDLE SHALL go to LOAD when a start is sampled (nwr_ready_in high) or a pending start is set.
REQ-014 LOAD SHALL capture the byte count, go to SEND after 1 cycle, and hold user_tvalid_o low.
  - Byte count rule: cfg_tsize_in values 0 and >256 clamp to 256.
  - Timing: user_tvalid_o rises on the second rising edge after nwr_ready_in is sampled.
REQ-015 SEND SHALL emit beats = ceil(bytes/KEEP_W) and go to DONE when the last beat is accepted (tvalid & tready).
REQ-016 DONE SHALL pulse nwr_done_o for exactly 1 cycle and go to IDLE.
REQ-017 All stream outputs SHALL hold stable while user_tvalid_o is high and user_tready_in is low.
REQ-018 user_tfirst_o SHALL be high on beat 0 only, and user_tlast_o on the final beat only; both SHALL be high together for a single-beat packet.
REQ-019 user_tkeep_o SHALL be all ones except on the last beat, where its low (bytes mod KEEP_W) bits are set; if the remainder is 0, it SHALL be all ones.
REQ-020 user_tsize_o SHALL equal bytes-1, zero-extended, constant for the whole packet.
REQ-021 user_addr_o SHALL be the packet start address, constant for the whole packet.
  - After each packet, the start address SHALL advance by the byte count, modulo 2^ADDR_W.
REQ-022 user_tdata_o SHALL replicate {pkt_seq[15:0], beat_idx[15:0]} across DATA_W/32 lanes.
  - pkt_seq increments after each packet and wraps at 16 bits.
REQ-023 nwr_busy_o SHALL be high in LOAD, SEND and DONE.
REQ-024 A start sampled while busy SHALL set a one-deep pending flag, which is consumed on the IDLE-to-LOAD transition.
REQ-025 A start sampled while busy with pending already set SHALL increment drop_cnt_o, saturating at 0xFFFF.
REQ-026 A start in the same cycle that DONE goes to IDLE SHALL set pending and SHALL NOT be dropped.

Reset
REQ-027 Reset assertion SHALL immediately clear the state to IDLE, clear pending, and set pkt_seq to 0 and drop_cnt_o to 0.
REQ-028 Reset assertion SHALL drive all stream outputs, nwr_busy_o and nwr_done_o to 0.
REQ-029 The address register SHALL load cfg_base_addr_in on the first clock after reset release.
REQ-030 Reset in mid-packet SHALL abandon the packet without asserting user_tlast_o or nwr_done_o.

Configuration
REQ-031 When macro SRIO_NWR_GEN_PRBS_EN is defined, user_tdata_o SHALL be a PRBS-31 (x^31+x^28+1) sequence.
  - Seed: 0x7FFFFFFF at reset.
  - Advance: 32 bits per lane per accepted beat, lanes ordered LSB first.
  - The generator SHALL hold when a beat is not accepted.
REQ-032 When the macro is undefined, user_tdata_o SHALL use the counter pattern of REQ-022.

Verification
REQ-033 DATA_W=64, tsize=256, base=0x1000, tready=1, one start -> 32 beats, tkeep=0xFF every beat, tsize_o=255, addr=0x1000, nwr_done_o 1 cycle after beat 31; the next packet's addr=0x1100.
REQ-034 DATA_W=64, tsize=13 -> 2 beats, last tkeep=0x1F; tsize=5 -> 1 beat with tfirst=tlast=1 and tkeep=0x1F.
REQ-035 DATA_W=128, tsize=0 -> 16 beats, tsize_o=255.
REQ-036 tready toggling 1/0 every cycle -> output held on stalled cycles, no lost or duplicated beat_idx.
REQ-037 Four starts during one busy packet -> one pending packet follows back-to-back, drop_cnt_o=2.
REQ-038 Reset asserted at beat 3 of 8 -> outputs 0 at once; after release, a new start emits pkt_seq=0 at cfg_base_addr_in.
